regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a destination scoreboard.
// State updates on the falling edge of c_clk; reset_n is async active-low.
//
// Ports:
//   c_clk, reset_n            clock (falling-edge active), async reset
//   rd_valid/rd_adr           per-port read enable and address (slice p)
//   rd_data/rd_busy           per-port read data and pending-write flag
//   adder_write_*             write port A (wins on address collision)
//   shift_write_*             write port B
//   rsv_valid/rsv_adr         destination reservation request
//   rsv_ready                 reservation can be accepted this cycle
//   busy_vec                  scoreboard, one bit per register
//
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching reads (rd_busy then reads 0 for that address).

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int RD_PORTS = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                       c_clk,
  input  logic                       reset_n,
  input  logic [RD_PORTS-1:0]        rd_valid,
  input  logic [RD_PORTS*AW-1:0]     rd_adr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic                       adder_write_valid,
  input  logic [AW-1:0]              adder_write_adr,
  input  logic [DATA_W-1:0]          adder_write_data,
  input  logic                       shift_write_valid,
  input  logic [AW-1:0]              shift_write_adr,
  input  logic [DATA_W-1:0]          shift_write_data,
  input  logic                       rsv_valid,
  input  logic [AW-1:0]              rsv_adr,
  output logic                       rsv_ready,
  output logic [NUM_REGS-1:0]        busy_vec
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wa;
  logic                wb;
  logic                rsv_acc;

  // Writes are masked while in reset so they cannot disturb rsv_ready
  // or the bypass path. Port B is dropped when it collides with A.
  assign wa = adder_write_valid & reset_n;
  assign wb = shift_write_valid & reset_n &
              ~(wa & (shift_write_adr == adder_write_adr));

  // A write landing on the requested register this cycle blocks the
  // reservation, so clear always beats set.
  assign rsv_ready = ~busy_vec[rsv_adr] &
                     ~(wa & (adder_write_adr == rsv_adr)) &
                     ~(wb & (shift_write_adr == rsv_adr));

  assign rsv_acc = rsv_valid & rsv_ready & reset_n;

  always_comb begin
    busy_nxt = busy_vec;
    if (rsv_acc) busy_nxt[rsv_adr] = 1'b1;
    if (wb) busy_nxt[shift_write_adr] = 1'b0;
    if (wa) busy_nxt[adder_write_adr] = 1'b0;
  end

  always_ff @(negedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_vec <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      busy_vec <= busy_nxt;
      if (wb) regs[shift_write_adr] <= shift_write_data;
      if (wa) regs[adder_write_adr] <= adder_write_data;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]     adr;
    logic [DATA_W-1:0] d;
    logic              b;

    assign adr = rd_adr[p*AW +: AW];

    always_comb begin
      d = regs[adr];
      b = busy_vec[adr];
`ifdef REGFILE_BYPASS_EN
      if (wa && adder_write_adr == adr) begin
        d = adder_write_data;
        b = 1'b0;
      end else if (wb && shift_write_adr == adr) begin
        d = shift_write_data;
        b = 1'b0;
      end
`else
`endif
    end

    assign rd_data[p*DATA_W +: DATA_W] = rd_valid[p] ? d : '0;
    assign rd_busy[p] = rd_valid[p] & b;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb against
// an array-based reference model; second instance for wide parameters.

module tb_regfile_sb;

  logic         c_clk;
  logic         reset_n;
  logic [3:0]   rd_valid;
  logic [15:0]  rd_adr;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic         aw_v;
  logic [3:0]   aw_a;
  logic [31:0]  aw_d;
  logic         sw_v;
  logic [3:0]   sw_a;
  logic [31:0]  sw_d;
  logic         rsv_valid;
  logic [3:0]   rsv_adr;
  logic         rsv_ready;
  logic [15:0]  busy_vec;

  logic [5:0]   x_rd_valid;
  logic [29:0]  x_rd_adr;
  logic [383:0] x_rd_data;
  logic [5:0]   x_rd_busy;
  logic         x_aw_v;
  logic [4:0]   x_aw_a;
  logic [63:0]  x_aw_d;
  logic         x_sw_v;
  logic [4:0]   x_sw_a;
  logic [63:0]  x_sw_d;
  logic         x_rsv_valid;
  logic [4:0]   x_rsv_adr;
  logic         x_rsv_ready;
  logic [31:0]  x_busy_vec;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [16];
  logic [15:0] m_busy;

  regfile_sb u_dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .rd_valid(rd_valid), .rd_adr(rd_adr),
    .rd_data(rd_data), .rd_busy(rd_busy),
    .adder_write_valid(aw_v), .adder_write_adr(aw_a),
    .adder_write_data(aw_d),
    .shift_write_valid(sw_v), .shift_write_adr(sw_a),
    .shift_write_data(sw_d),
    .rsv_valid(rsv_valid), .rsv_adr(rsv_adr),
    .rsv_ready(rsv_ready), .busy_vec(busy_vec)
  );

  regfile_sb #(.DATA_W(64), .NUM_REGS(32), .RD_PORTS(6)) u_wide (
    .c_clk(c_clk), .reset_n(reset_n),
    .rd_valid(x_rd_valid), .rd_adr(x_rd_adr),
    .rd_data(x_rd_data), .rd_busy(x_rd_busy),
    .adder_write_valid(x_aw_v), .adder_write_adr(x_aw_a),
    .adder_write_data(x_aw_d),
    .shift_write_valid(x_sw_v), .shift_write_adr(x_sw_a),
    .shift_write_data(x_sw_d),
    .rsv_valid(x_rsv_valid), .rsv_adr(x_rsv_adr),
    .rsv_ready(x_rsv_ready), .busy_vec(x_busy_vec)
  );

  initial begin
    c_clk = 1'b1;
    forever #5 c_clk = ~c_clk;
  end

  // Reference model: what a read should return given the model state
  // and the inputs currently applied.
  function automatic logic [31:0] exp_data(int p);
    logic [3:0]  a;
    logic [31:0] d;
    a = rd_adr[p*4 +: 4];
    if (!reset_n || !rd_valid[p]) return 32'h0;
    d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    if (aw_v && aw_a == a) d = aw_d;
    else if (sw_v && sw_a == a) d = sw_d;
`endif
    return d;
  endfunction

  function automatic logic exp_busy(int p);
    logic [3:0] a;
    logic       b;
    a = rd_adr[p*4 +: 4];
    if (!reset_n || !rd_valid[p]) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if ((aw_v && aw_a == a) || (sw_v && sw_a == a)) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic exp_ready();
    if (!reset_n) return 1'b1;
    if (m_busy[rsv_adr]) return 1'b0;
    if (aw_v && aw_a == rsv_adr) return 1'b0;
    if (sw_v && sw_a == rsv_adr) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_busy = '0;
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
  endtask

  // Apply the falling edge to the model, then advance past it.
  task automatic edge_step();
    logic r;
    if (!reset_n) begin
      model_clear();
    end else begin
      r = exp_ready();
      if (rsv_valid && r) m_busy[rsv_adr] = 1'b1;
      if (sw_v) begin
        m_reg[sw_a] = sw_d;
        m_busy[sw_a] = 1'b0;
      end
      if (aw_v) begin
        m_reg[aw_a] = aw_d;
        m_busy[aw_a] = 1'b0;
      end
    end
    @(negedge c_clk);
    #1;
  endtask

  task automatic idle();
    rd_valid = '0; rd_adr = '0;
    aw_v = 0; aw_a = '0; aw_d = '0;
    sw_v = 0; sw_a = '0; sw_d = '0;
    rsv_valid = 0; rsv_adr = '0;
  endtask

  task automatic rand_inputs();
    rd_valid = 4'($urandom);
    for (int p = 0; p < 4; p++) rd_adr[p*4 +: 4] = 4'($urandom_range(0, 7));
    aw_v = ($urandom % 3) == 0;
    aw_a = 4'($urandom_range(0, 7));
    aw_d = $urandom;
    sw_v = ($urandom % 3) == 0;
    sw_a = 4'($urandom_range(0, 7));
    sw_d = $urandom;
    rsv_valid = 1'($urandom);
    rsv_adr = 4'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      rand_inputs();
      @(posedge c_clk);
      edge_step();
    end
    idle();
    rsv_valid = 1; rsv_adr = 4'd9;
    @(posedge c_clk);
    edge_step();
    @(posedge c_clk);
    #2;
    reset_n = 0;
    model_clear();
    for (int a = 0; a < 4; a++) begin
      rand_inputs();
      rd_valid = 4'hF;
      for (int p = 0; p < 4; p++) rd_adr[p*4 +: 4] = 4'(a*4 + p);
      @(posedge c_clk);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rd_data[p*32 +: 32] !== 32'h0) begin
          errors++;
          $display("FAIL reset_data p%0d: got %h exp 0", p, rd_data[p*32 +: 32]);
        end
        checks++;
        if (rd_busy[p] !== 1'b0) begin
          errors++;
          $display("FAIL reset_busy p%0d: got %b exp 0", p, rd_busy[p]);
        end
      end
      checks++;
      if (busy_vec !== 16'h0 || rsv_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_sb: busy_vec %h rsv_ready %b exp 0000/1", busy_vec, rsv_ready);
      end
      edge_step();
    end
    idle();
    #2;
    reset_n = 1;
    aw_v = 1; aw_a = 4'd2; aw_d = 32'hCAFE0001;
    @(posedge c_clk);
    edge_step();
    idle();
    rd_valid = 4'b0001; rd_adr = 16'h0002;
    @(posedge c_clk);
    checks++;
    if (rd_data[31:0] !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL first_edge: got %h exp cafe0001", rd_data[31:0]);
    end
    checks++;
    if (busy_vec[9] !== 1'b0) begin
      errors++;
      $display("FAIL rsv_dropped: busy_vec[9]=%b exp 0", busy_vec[9]);
    end
    edge_step();
  endtask

  task automatic test_reserve_wb();
    idle();
    rsv_valid = 1; rsv_adr = 4'd5;
    @(posedge c_clk);
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsv_first: rsv_ready %b exp 1", rsv_ready);
    end
    edge_step();
    rd_valid = 4'b0001; rd_adr = 16'h0005;
    @(posedge c_clk);
    checks++;
    if (rsv_ready !== 1'b0) begin
      errors++;
      $display("FAIL rsv_again: rsv_ready %b exp 0", rsv_ready);
    end
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rsv_rd_busy: got %b exp 1", rd_busy[0]);
    end
    edge_step();
    rsv_valid = 0;
    aw_v = 1; aw_a = 4'd5; aw_d = 32'hA5A5A5A5;
    @(posedge c_clk);
    checks++;
    if (rd_data[31:0] !== exp_data(0) || rd_busy[0] !== exp_busy(0)) begin
      errors++;
      $display("FAIL wb_cycle: got %h/%b exp %h/%b", rd_data[31:0], rd_busy[0], exp_data(0), exp_busy(0));
    end
    edge_step();
    aw_v = 0;
    @(posedge c_clk);
    checks++;
    if (busy_vec[5] !== 1'b0 || rd_data[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL wb_after: busy %b data %h exp 0/a5a5a5a5", busy_vec[5], rd_data[31:0]);
    end
    edge_step();
  endtask

  task automatic test_collision();
    idle();
    aw_v = 1; aw_a = 4'd13; aw_d = 32'h11111111;
    sw_v = 1; sw_a = 4'd13; sw_d = 32'h22222222;
    @(posedge c_clk);
    edge_step();
    idle();
    rd_valid = 4'hF; rd_adr = 16'hDDDD;
    @(posedge c_clk);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_data[p*32 +: 32] !== 32'h11111111) begin
        errors++;
        $display("FAIL collision p%0d: got %h exp 11111111", p, rd_data[p*32 +: 32]);
      end
    end
    edge_step();
  endtask

  task automatic test_rsv_write_same();
    idle();
    rsv_valid = 1; rsv_adr = 4'd3;
    sw_v = 1; sw_a = 4'd3; sw_d = 32'h33333333;
    @(posedge c_clk);
    checks++;
    if (rsv_ready !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_ready: got %b exp 0", rsv_ready);
    end
    edge_step();
    idle();
    @(posedge c_clk);
    checks++;
    if (busy_vec[3] !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_busy: got %b exp 0", busy_vec[3]);
    end
    edge_step();
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    logic        wantb;
    idle();
    aw_v = 1; aw_a = 4'd7; aw_d = 32'h12345678;
    @(posedge c_clk);
    edge_step();
    idle();
    rsv_valid = 1; rsv_adr = 4'd7;
    @(posedge c_clk);
    edge_step();
    idle();
    aw_v = 1; aw_a = 4'd7; aw_d = 32'hDEADBEEF;
    rd_valid = 4'b0001; rd_adr = 16'h0007;
`ifdef REGFILE_BYPASS_EN
    want = 32'hDEADBEEF; wantb = 1'b0;
`else
    want = 32'h12345678; wantb = 1'b1;
`endif
    @(posedge c_clk);
    checks++;
    if (rd_data[31:0] !== want || rd_busy[0] !== wantb) begin
      errors++;
      $display("FAIL bypass_same: got %h/%b exp %h/%b", rd_data[31:0], rd_busy[0], want, wantb);
    end
    edge_step();
    aw_v = 0;
    @(posedge c_clk);
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_next: got %h/%b exp deadbeef/0", rd_data[31:0], rd_busy[0]);
    end
    edge_step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      @(posedge c_clk);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rd_data[p*32 +: 32] !== exp_data(p)) begin
          errors++;
          $display("FAIL rnd_data c%0d p%0d: got %h exp %h", c, p, rd_data[p*32 +: 32], exp_data(p));
        end
        checks++;
        if (rd_busy[p] !== exp_busy(p)) begin
          errors++;
          $display("FAIL rnd_busy c%0d p%0d: got %b exp %b", c, p, rd_busy[p], exp_busy(p));
        end
      end
      checks++;
      if (rsv_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rnd_ready c%0d: got %b exp %b", c, rsv_ready, exp_ready());
      end
      checks++;
      if (busy_vec !== m_busy) begin
        errors++;
        $display("FAIL rnd_busy_vec c%0d: got %h exp %h", c, busy_vec, m_busy);
      end
      edge_step();
    end
    idle();
  endtask

  task automatic test_sweep();
    logic [63:0] want;
    idle();
    x_aw_v = 1; x_aw_a = 5'd31; x_aw_d = 64'hFFFF_0000_FFFF_0000;
    @(posedge c_clk);
    edge_step();
    x_aw_v = 0;
    x_rd_valid = 6'h3F; x_rd_adr = {6{5'd31}};
    @(posedge c_clk);
    for (int p = 0; p < 6; p++) begin
      checks++;
      if (x_rd_data[p*64 +: 64] !== 64'hFFFF_0000_FFFF_0000) begin
        errors++;
        $display("FAIL wide_all p%0d: got %h", p, x_rd_data[p*64 +: 64]);
      end
    end
    x_rd_valid = 6'b010101;
    #1;
    for (int p = 0; p < 6; p++) begin
      want = x_rd_valid[p] ? 64'hFFFF_0000_FFFF_0000 : 64'h0;
      checks++;
      if (x_rd_data[p*64 +: 64] !== want || x_rd_busy[p] !== 1'b0) begin
        errors++;
        $display("FAIL wide_mask p%0d: got %h/%b exp %h/0", p, x_rd_data[p*64 +: 64], x_rd_busy[p], want);
      end
    end
    edge_step();
    x_rd_valid = '0;
  endtask

  initial begin
    reset_n = 0;
    idle();
    x_rd_valid = '0; x_rd_adr = '0;
    x_aw_v = 0; x_aw_a = '0; x_aw_d = '0;
    x_sw_v = 0; x_sw_a = '0; x_sw_d = '0;
    x_rsv_valid = 0; x_rsv_adr = '0;
    model_clear();
    repeat (2) @(negedge c_clk);
    #1;
    reset_n = 1;
    test_reset();
    test_reserve_wb();
    test_collision();
    test_rsv_write_same();
    test_bypass();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
